fifo_sync_flags: RTL
====================

# fifo_sync_flags

Parametrised single-clock synchronous FIFO, the successor to the basic FIFO used in the SoC data paths, e.g. between the PicoRV32 bus side and the DDR model. It adds:
- programmable almost-full and almost-empty thresholds
- an occupancy count
- sticky overflow and underflow error flags
- a selectable read mode: standard registered read, or first-word-fall-through (FWFT)

## Interface
- DATA_WIDTH, 32, word width in bits
- DEPTH, 8, number of entries; must be a power of two and at least 2 (elaboration-time check, `$fatal` otherwise)
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- full  out  1  no free entries
- almost_full  out  1  count >= AF_THRESH
- rd_en  in  1  read request (in FWFT mode: pop/acknowledge)
- data_out  out  DATA_WIDTH  read data
- rd_valid  out  1  data_out holds a valid word (see Timing)
- empty  out  1  no stored entries
- almost_empty  out  1  count <= AE_THRESH
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected
- clr_err  in  1  synchronous clear of overflow and underflow

## Operation
- Storage is a DEPTH x DATA_WIDTH register array.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - count is tracked separately and is the sole source of every flag.
- Acceptance rules:
  - rd_acc = rd_en && !empty
  - wr_acc = wr_en && (!full || rd_acc)
  - When full, a write is accepted only if a read is accepted in the same cycle.
  - When empty, a simultaneous read is rejected and the write is accepted.
- Count update: count_next = count + wr_acc - rd_acc. Simultaneous accepted read and write leaves count unchanged.
- Flags:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full = (count >= AF_THRESH)
  - almost_empty = (count <= AE_THRESH)
  - All are registered and computed from count_next, so they are exact in the same cycle as count.
- Error flags:
  - overflow is set when wr_en && !wr_acc.
  - underflow is set when rd_en && empty.
  - Both are cleared by clr_err. If set and clear occur in the same cycle, set wins.
- Standard mode (FWFT=0): on rd_acc, data_out <= mem[rd_ptr] and rd_valid pulses high for exactly one cycle. Otherwise data_out holds its value and rd_valid = 0.
- FWFT mode (FWFT=1):
  - data_out continuously presents mem[rd_ptr] and rd_valid = !empty.
  - rd_en with rd_valid pops the head word; the next word appears the following cycle.
  - While empty, data_out holds its last value.
- Reset (asynchronous, valid mid-operation): pointers and count go to 0 immediately and all in-flight data is discarded. Array contents need not be cleared.

## Timing
- Reset values:
  - empty = 1, almost_empty = 1
  - full = 0, almost_full = 0, count = 0
  - data_out = 0, rd_valid = 0
  - overflow = 0, underflow = 0
- Write latency: the word is written at the edge where wr_acc = 1. count and flags update at that same edge.
- Standard read latency: rd_en sampled at edge N; data_out and rd_valid are valid after edge N (one cycle).
- FWFT latency: after a write into an empty FIFO at edge N, empty = 0, rd_valid = 1 and data_out = word after edge N.
- No combinational path from wr_en or rd_en to any output. In FWFT mode data_out depends only on registered state.

## Test plan
- Reset, then reset asserted mid-stream with count=5 -> outputs return immediately to the reset values listed above; a subsequent write of 0x1 reads back 0x1.
- FWFT=0, DEPTH=8, write 0x11..0x88:
  - almost_full rises when count reaches 6; full after the 8th write.
  - A 9th write of 0x99 is rejected: overflow = 1, count = 8.
  - Eight reads return 0x11..0x88 in order, each with a one-cycle rd_valid pulse.
  - empty = 1 after the last read.
- Full FIFO with rd_en and wr_en=0xAA in the same cycle -> both accepted, count stays 8, overflow stays 0; 0xAA is read out last.
- Empty FIFO:
  - rd_en -> underflow = 1, rd_valid = 0, data_out unchanged.
  - rd_en + wr_en(0x5) together -> write accepted, count = 1.
  - clr_err -> underflow = 0.
- FWFT=1: write 0xA5 into an empty FIFO -> next cycle data_out = 0xA5 and rd_valid = 1 with no rd_en; rd_en then pops it, giving empty = 1 and rd_valid = 0.
- Pointer wrap: 20 interleaved write/read pairs of an incrementing pattern starting at 0x100, with count held between 1 and 3 -> output order is exact across wrap, and no error flags are set.

Source files
------------

// File: rtl/fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// fifo_sync_flags : single-clock FIFO with occupancy count, threshold flags,
//                   sticky overflow/underflow and optional first-word-fall-through
// Revision        : 1.0
// ============================================================================
module fifo_sync_flags #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic                    full,
  output logic                    almost_full,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  output logic                    empty,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $fatal(1, "fifo_sync_flags: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [CW-1:0]         count_next;

  // A full FIFO may still take a write when a read frees a slot in the same cycle.
  assign rd_acc     = rd_en && !empty;
  assign wr_acc     = wr_en && (!full || rd_acc);
  assign count_next = count + CW'(wr_acc) - CW'(rd_acc);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count        <= count_next;
      full         <= (int'(count_next) == DEPTH);
      empty        <= (count_next == '0);
      almost_full  <= (int'(count_next) >= AF_THRESH);
      almost_empty <= (int'(count_next) <= AE_THRESH);
      // Set has priority over a same-cycle clear.
      overflow     <= (overflow  && !clr_err) || (wr_en && !wr_acc);
      underflow    <= (underflow && !clr_err) || (rd_en && empty);
    end
  end

  if (FWFT != 0) begin : g_fwft
    logic [DATA_WIDTH-1:0] hold;

    // Remembers the last popped word so data_out is stable while empty.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hold <= '0;
      end else if (rd_acc) begin
        hold <= mem[rd_ptr];
      end
    end

    assign data_out = empty ? hold : mem[rd_ptr];
    assign rd_valid = !empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  valid_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) dout_q <= mem[rd_ptr];
      end
    end

    assign data_out = dout_q;
    assign rd_valid = valid_q;
  end

endmodule
`default_nettype wire
